// File: rtl/tx_rd_mem_req_mux.sv
// tx_rd_mem_req_mux: N-source round-robin front end for one payload read engine.
// Requests are arbitrated into a single registered output slot; the issuing source id
// is queued in an in-order tag FIFO so returned data beats are steered back to it.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 16
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module tx_rd_mem_req_mux #(
  parameter int NUM_SRC   = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_SRC-1:0]                        src_req_val,
  input  logic [NUM_SRC*`FLOW_ID_W-1:0]             src_req_flowid,
  input  logic [NUM_SRC*`PAYLOAD_PTR_W-1:0]         src_req_offset,
  input  logic [NUM_SRC*`MSG_DATA_SIZE_WIDTH-1:0]   src_req_size,
  output logic [NUM_SRC-1:0]                        src_req_rdy,
  output logic                                      eng_req_val,
  output logic [`FLOW_ID_W-1:0]                     eng_req_flowid,
  output logic [`PAYLOAD_PTR_W-1:0]                 eng_req_offset,
  output logic [`MSG_DATA_SIZE_WIDTH-1:0]           eng_req_size,
  input  logic                                      eng_req_rdy,
  input  logic                                      eng_data_val,
  input  logic                                      eng_data_last,
  input  logic [`MAC_INTERFACE_W-1:0]               eng_data,
  input  logic [`MAC_PADBYTES_W-1:0]                eng_data_padbytes,
  output logic                                      eng_data_rdy,
  output logic [NUM_SRC-1:0]                        dst_data_val,
  output logic [`MAC_INTERFACE_W-1:0]               dst_data,
  output logic                                      dst_data_last,
  output logic [`MAC_PADBYTES_W-1:0]                dst_data_padbytes,
  input  logic [NUM_SRC-1:0]                        dst_data_rdy,
  output logic [$clog2(TAG_DEPTH):0]                outstanding_cnt,
  output logic                                      proto_err
);

  localparam int SRC_ID_W = $clog2(NUM_SRC);
  localparam int PTR_W    = $clog2(TAG_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int FW       = `FLOW_ID_W;
  localparam int PW       = `PAYLOAD_PTR_W;
  localparam int SW       = `MSG_DATA_SIZE_WIDTH;

  logic [SRC_ID_W-1:0] rr_ptr;
  logic [NUM_SRC-1:0]  grant;
  logic [SRC_ID_W-1:0] grant_idx;
  logic [FW-1:0]       sel_flowid;
  logic [PW-1:0]       sel_offset;
  logic [SW-1:0]       sel_size;
  logic                can_accept;
  logic                accept;

  logic                vld_p1;
  logic [FW-1:0]       flowid_p1;
  logic [PW-1:0]       offset_p1;
  logic [SW-1:0]       size_p1;

  logic [SRC_ID_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [SRC_ID_W-1:0] head;
  logic                empty;
  logic                push;
  logic                pop;

  // Round-robin scan starting just after the last granted source
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!found && src_req_val[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = SRC_ID_W'(idx);
      end
    end
  end

  // Select the granted source's request fields
  always_comb begin
    sel_flowid = '0;
    sel_offset = '0;
    sel_size   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_flowid = src_req_flowid[i*FW +: FW];
        sel_offset = src_req_offset[i*PW +: PW];
        sel_size   = src_req_size[i*SW +: SW];
      end
    end
  end

  // The output slot frees up in the same cycle the engine takes it; a full tag FIFO blocks
  assign can_accept  = (!vld_p1 || eng_req_rdy) && (cnt < CNT_W'(TAG_DEPTH));
  assign src_req_rdy = rst_n ? ({NUM_SRC{can_accept}} & grant) : '0;
  assign accept      = |(src_req_val & src_req_rdy);

  // Stage p1: output slot valid and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      rr_ptr <= SRC_ID_W'(NUM_SRC - 1);
    end else begin
      if (accept) begin
        vld_p1 <= 1'b1;
        rr_ptr <= grant_idx;
      end else if (eng_req_rdy) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Stage p1: output slot payload, held while the engine stalls
  always_ff @(posedge clk) begin
    if (accept) begin
      flowid_p1 <= sel_flowid;
      offset_p1 <= sel_offset;
      size_p1   <= sel_size;
    end
  end

  assign eng_req_val    = vld_p1;
  assign eng_req_flowid = flowid_p1;
  assign eng_req_offset = offset_p1;
  assign eng_req_size   = size_p1;

  // Tag FIFO: a slot is held from accept until the last beat of that request is handed off
  assign push  = accept;
  assign empty = (cnt == '0);
  assign head  = tag_mem[rd_ptr];
  assign pop   = eng_data_val && eng_data_rdy && eng_data_last;

  // Tag storage writes
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= grant_idx;
    end
  end

  // Tag FIFO pointers, occupancy and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      proto_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (eng_data_val && empty) proto_err <= 1'b1;
    end
  end

  assign outstanding_cnt = cnt;

  // Steer returned beats to the source at the tag FIFO head
  always_comb begin
    dst_data_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dst_data_val[i] = eng_data_val && !empty && (head == SRC_ID_W'(i));
    end
  end

  assign eng_data_rdy      = dst_data_rdy[head] && !empty;
  assign dst_data          = eng_data;
  assign dst_data_last     = eng_data_last;
  assign dst_data_padbytes = eng_data_padbytes;

endmodule

// File: tb/tb_tx_rd_mem_req_mux.sv
// Bench for tx_rd_mem_req_mux: scoreboard of expected engine requests and data beats,
// plus per-scenario inline checks of arbitration, occupancy, routing and error flag.

`ifndef FLOW_ID_W
`define FLOW_ID_W 8
`endif
`ifndef PAYLOAD_PTR_W
`define PAYLOAD_PTR_W 16
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 16
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 64
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 3
`endif

module tb_tx_rd_mem_req_mux;

  localparam int NUM_SRC   = 4;
  localparam int TAG_DEPTH = 8;
  localparam int FW  = `FLOW_ID_W;
  localparam int PW  = `PAYLOAD_PTR_W;
  localparam int SW  = `MSG_DATA_SIZE_WIDTH;
  localparam int DW  = `MAC_INTERFACE_W;
  localparam int PDW = `MAC_PADBYTES_W;

  typedef struct {
    logic [FW-1:0] flow;
    logic [PW-1:0] off;
    logic [SW-1:0] size;
  } req_t;

  typedef struct {
    int             src;
    logic [DW-1:0]  data;
    logic           last;
    logic [PDW-1:0] pad;
  } beat_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_SRC-1:0]        src_req_val;
  logic [NUM_SRC*FW-1:0]     src_req_flowid;
  logic [NUM_SRC*PW-1:0]     src_req_offset;
  logic [NUM_SRC*SW-1:0]     src_req_size;
  logic [NUM_SRC-1:0]        src_req_rdy;
  logic                      eng_req_val;
  logic [FW-1:0]             eng_req_flowid;
  logic [PW-1:0]             eng_req_offset;
  logic [SW-1:0]             eng_req_size;
  logic                      eng_req_rdy;
  logic                      eng_data_val;
  logic                      eng_data_last;
  logic [DW-1:0]             eng_data;
  logic [PDW-1:0]            eng_data_padbytes;
  logic                      eng_data_rdy;
  logic [NUM_SRC-1:0]        dst_data_val;
  logic [DW-1:0]             dst_data;
  logic                      dst_data_last;
  logic [PDW-1:0]            dst_data_padbytes;
  logic [NUM_SRC-1:0]        dst_data_rdy;
  logic [$clog2(TAG_DEPTH):0] outstanding_cnt;
  logic                      proto_err;

  logic [FW-1:0] f_flow [NUM_SRC];
  logic [PW-1:0] f_off  [NUM_SRC];
  logic [SW-1:0] f_size [NUM_SRC];

  req_t  exp_req_q [$];
  beat_t exp_beat_q [$];
  int    model_tags [$];
  int    tests = 0;
  int    fails = 0;
  bit    sb_en = 1'b1;

  always #5 clk = ~clk;

  always_comb begin
    src_req_flowid = '0;
    src_req_offset = '0;
    src_req_size   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_req_flowid[i*FW +: FW] = f_flow[i];
      src_req_offset[i*PW +: PW] = f_off[i];
      src_req_size[i*SW +: SW]   = f_size[i];
    end
  end

  tx_rd_mem_req_mux #(.NUM_SRC(NUM_SRC), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req_val(src_req_val), .src_req_flowid(src_req_flowid),
    .src_req_offset(src_req_offset), .src_req_size(src_req_size),
    .src_req_rdy(src_req_rdy),
    .eng_req_val(eng_req_val), .eng_req_flowid(eng_req_flowid),
    .eng_req_offset(eng_req_offset), .eng_req_size(eng_req_size),
    .eng_req_rdy(eng_req_rdy),
    .eng_data_val(eng_data_val), .eng_data_last(eng_data_last),
    .eng_data(eng_data), .eng_data_padbytes(eng_data_padbytes),
    .eng_data_rdy(eng_data_rdy),
    .dst_data_val(dst_data_val), .dst_data(dst_data),
    .dst_data_last(dst_data_last), .dst_data_padbytes(dst_data_padbytes),
    .dst_data_rdy(dst_data_rdy),
    .outstanding_cnt(outstanding_cnt), .proto_err(proto_err)
  );

  // Scoreboard: inputs change just after posedge, so a val&rdy seen at negedge is a handshake
  always @(negedge clk) begin : sb
    req_t  er;
    beat_t eb;
    if (sb_en && rst_n) begin
      if (eng_req_val && eng_req_rdy) begin
        tests++;
        if (exp_req_q.size() == 0) begin
          fails++;
          $display("FAIL sb_req_unexpected: got flow=%0h off=%0h size=%0d, expected none",
                   eng_req_flowid, eng_req_offset, eng_req_size);
        end else begin
          er = exp_req_q.pop_front();
          if ({eng_req_flowid, eng_req_offset, eng_req_size} !== {er.flow, er.off, er.size}) begin
            fails++;
            $display("FAIL sb_req_fields: got flow=%0h off=%0h size=%0d, expected flow=%0h off=%0h size=%0d",
                     eng_req_flowid, eng_req_offset, eng_req_size, er.flow, er.off, er.size);
          end
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (dst_data_val[i] && dst_data_rdy[i]) begin
          tests++;
          if (exp_beat_q.size() == 0) begin
            fails++;
            $display("FAIL sb_beat_unexpected: got src=%0d data=%0h, expected none", i, dst_data);
          end else begin
            eb = exp_beat_q.pop_front();
            if (i != eb.src || dst_data !== eb.data || dst_data_last !== eb.last ||
                (eb.last && dst_data_padbytes !== eb.pad)) begin
              fails++;
              $display("FAIL sb_beat: got src=%0d data=%0h last=%0b pad=%0d, expected src=%0d data=%0h last=%0b pad=%0d",
                       i, dst_data, dst_data_last, dst_data_padbytes, eb.src, eb.data, eb.last, eb.pad);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic default_fields();
    for (int i = 0; i < NUM_SRC; i++) begin
      f_flow[i] = FW'(8'h10 + i);
      f_off[i]  = PW'(16'h100 * i + 16'h8);
      f_size[i] = SW'(8 * (i + 1));
    end
  endtask

  task automatic idle_inputs();
    src_req_val       = '0;
    eng_req_rdy       = 1'b0;
    eng_data_val      = 1'b0;
    eng_data_last     = 1'b0;
    eng_data          = '0;
    eng_data_padbytes = '0;
    dst_data_rdy      = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    exp_req_q.delete();
    exp_beat_q.delete();
    model_tags.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_req(input int s);
    exp_req_q.push_back('{f_flow[s], f_off[s], f_size[s]});
    model_tags.push_back(s);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_req_q.size() != 0 || exp_beat_q.size() != 0) begin
      fails++;
      $display("FAIL %s_queues: got req_left=%0d beat_left=%0d, expected 0/0",
               name, exp_req_q.size(), exp_beat_q.size());
    end
  endtask

  // Return n single-beat responses, one per outstanding tag in model order
  task automatic drain(input int n);
    int    s;
    int    cyc;
    bit    done;
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      s = (model_tags.size() > 0) ? model_tags.pop_front() : -1;
      d = DW'(64'hD000 + k);
      eng_data          = d;
      eng_data_last     = 1'b1;
      eng_data_padbytes = PDW'(k);
      eng_data_val      = 1'b1;
      dst_data_rdy      = '1;
      exp_beat_q.push_back('{s, d, 1'b1, PDW'(k)});
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        done = eng_data_rdy;
        tick();
        cyc++;
      end
      tests++;
      if (!done) begin
        fails++;
        $display("FAIL drain_timeout: got no handoff for beat %0d, expected handoff", k);
      end
    end
    eng_data_val  = 1'b0;
    eng_data_last = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    src_req_val = '1;
    eng_data_val = 1'b1;
    dst_data_rdy = '1;
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({eng_req_val, src_req_rdy, dst_data_val, eng_data_rdy, outstanding_cnt, proto_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got val=%0b rdy=%b dval=%b drdy=%0b cnt=%0d err=%0b, expected all 0",
               eng_req_val, src_req_rdy, dst_data_val, eng_data_rdy, outstanding_cnt, proto_err);
    end
    apply_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    apply_reset();
    f_flow[2] = FW'(5);
    f_off[2]  = PW'(16'h40);
    f_size[2] = SW'(64);
    src_req_val = 4'b0100;
    eng_req_rdy = 1'b1;
    push_req(2);
    @(negedge clk);
    tests++;
    if (src_req_rdy !== 4'b0100 || eng_req_val !== 1'b0) begin
      fails++;
      $display("FAIL single_grant: got rdy=%b val=%0b, expected rdy=0100 val=0", src_req_rdy, eng_req_val);
    end
    tick();
    src_req_val = '0;
    @(negedge clk);
    tests++;
    if (eng_req_val !== 1'b1 || eng_req_flowid !== FW'(5) || eng_req_offset !== PW'(16'h40) ||
        eng_req_size !== SW'(64) || outstanding_cnt !== 4'd1) begin
      fails++;
      $display("FAIL single_req: got val=%0b flow=%0h off=%0h size=%0d cnt=%0d, expected 1/5/40/64/1",
               eng_req_val, eng_req_flowid, eng_req_offset, eng_req_size, outstanding_cnt);
    end
    tick();
    d = DW'(64'h1234_5678_9ABC_DEF0);
    eng_data = d;
    eng_data_last = 1'b1;
    eng_data_padbytes = PDW'(3);
    eng_data_val = 1'b1;
    dst_data_rdy = '1;
    exp_beat_q.push_back('{model_tags.pop_front(), d, 1'b1, PDW'(3)});
    @(negedge clk);
    tests++;
    if (dst_data_val !== 4'b0100 || eng_data_rdy !== 1'b1) begin
      fails++;
      $display("FAIL single_route: got dval=%b drdy=%0b, expected 0100/1", dst_data_val, eng_data_rdy);
    end
    tick();
    eng_data_val = 1'b0;
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL single_cnt: got %0d, expected 0", outstanding_cnt);
    end
    default_fields();
    check_drained("single");
  endtask

  task automatic test_fairness();
    int p;
    int tally [NUM_SRC];
    apply_reset();
    for (int i = 0; i < NUM_SRC; i++) tally[i] = 0;
    eng_req_rdy = 1'b1;
    src_req_val = '1;
    p = NUM_SRC - 1;
    for (int g = 0; g < 8; g++) begin
      p = (p + 1) % NUM_SRC;
      push_req(p);
      @(negedge clk);
      tests++;
      if (src_req_rdy !== NUM_SRC'(1 << p)) begin
        fails++;
        $display("FAIL fair_order: grant %0d got rdy=%b, expected src %0d", g, src_req_rdy, p);
      end
      for (int i = 0; i < NUM_SRC; i++) if (src_req_rdy[i]) tally[i]++;
      tick();
    end
    src_req_val = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      tests++;
      if (tally[i] != 2) begin
        fails++;
        $display("FAIL fair_share: src %0d got %0d grants, expected 2", i, tally[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd8) begin
      fails++;
      $display("FAIL fair_cnt: got %0d, expected 8", outstanding_cnt);
    end
    tick();
    drain(8);
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL fair_cnt_end: got %0d, expected 0", outstanding_cnt);
    end
    check_drained("fair");
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    apply_reset();
    eng_req_rdy = 1'b1;
    src_req_val = 4'b0001;
    for (int k = 0; k < TAG_DEPTH; k++) begin
      push_req(0);
      tick();
    end
    src_req_val = '1;
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd8 || src_req_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL full_block: got cnt=%0d rdy=%b, expected 8/0000", outstanding_cnt, src_req_rdy);
    end
    tick();
    d = DW'(64'hF00D);
    eng_data = d;
    eng_data_last = 1'b1;
    eng_data_padbytes = PDW'(1);
    eng_data_val = 1'b1;
    dst_data_rdy = '1;
    exp_beat_q.push_back('{model_tags.pop_front(), d, 1'b1, PDW'(1)});
    @(negedge clk);
    tests++;
    if (eng_data_rdy !== 1'b1 || src_req_rdy !== 4'b0000) begin
      fails++;
      $display("FAIL full_nobypass: got drdy=%0b rdy=%b, expected 1/0000", eng_data_rdy, src_req_rdy);
    end
    tick();
    eng_data_val = 1'b0;
    push_req(1);
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd7 || src_req_rdy !== 4'b0010) begin
      fails++;
      $display("FAIL full_release: got cnt=%0d rdy=%b, expected 7/0010", outstanding_cnt, src_req_rdy);
    end
    tick();
    src_req_val = '0;
    drain(8);
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL full_cnt_end: got %0d, expected 0", outstanding_cnt);
    end
    check_drained("full");
  endtask

  task automatic test_routing();
    logic [DW-1:0]  bd   [4];
    logic           bl   [4];
    logic [PDW-1:0] bp   [4];
    int             bs   [4];
    int             b;
    int             cyc;
    logic           tg;
    logic [NUM_SRC-1:0] expv;
    apply_reset();
    eng_req_rdy = 1'b1;
    src_req_val = 4'b0010;
    push_req(1);
    tick();
    src_req_val = 4'b1000;
    push_req(3);
    tick();
    src_req_val = '0;
    bs[0] = model_tags.pop_front();
    bs[1] = bs[0];
    bs[2] = bs[0];
    bs[3] = model_tags.pop_front();
    for (int k = 0; k < 4; k++) begin
      bd[k] = DW'(64'hA0 + k);
      bl[k] = (k == 2 || k == 3);
      bp[k] = PDW'(k + 3);
      exp_beat_q.push_back('{bs[k], bd[k], bl[k], bp[k]});
    end
    b = 0;
    cyc = 0;
    tg = 1'b0;
    while (b < 4 && cyc < 40) begin
      tg = ~tg;
      dst_data_rdy = {1'b1, 1'b0, tg, 1'b0};
      eng_data = bd[b];
      eng_data_last = bl[b];
      eng_data_padbytes = bp[b];
      eng_data_val = 1'b1;
      @(negedge clk);
      expv = (b < 3) ? 4'b0010 : 4'b1000;
      tests++;
      if (dst_data_val !== expv || eng_data_rdy !== ((b < 3) ? tg : 1'b1)) begin
        fails++;
        $display("FAIL route_beat%0d: got dval=%b drdy=%0b, expected dval=%b drdy=%0b",
                 b, dst_data_val, eng_data_rdy, expv, (b < 3) ? tg : 1'b1);
      end
      if (eng_data_rdy) b++;
      tick();
      cyc++;
    end
    eng_data_val = 1'b0;
    tests++;
    if (b != 4) begin
      fails++;
      $display("FAIL route_timeout: got %0d beats, expected 4", b);
    end
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL route_cnt: got %0d, expected 0", outstanding_cnt);
    end
    check_drained("route");
  endtask

  task automatic test_error();
    apply_reset();
    eng_data_val = 1'b1;
    eng_data_last = 1'b1;
    dst_data_rdy = '1;
    @(negedge clk);
    tests++;
    if (eng_data_rdy !== 1'b0 || dst_data_val !== 4'b0000 || proto_err !== 1'b0) begin
      fails++;
      $display("FAIL err_stall: got drdy=%0b dval=%b err=%0b, expected 0/0000/0",
               eng_data_rdy, dst_data_val, proto_err);
    end
    tick();
    eng_data_val = 1'b0;
    @(negedge clk);
    tests++;
    if (proto_err !== 1'b1) begin
      fails++;
      $display("FAIL err_set: got %0b, expected 1", proto_err);
    end
    repeat (3) tick();
    @(negedge clk);
    tests++;
    if (proto_err !== 1'b1 || outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL err_hold: got err=%0b cnt=%0d, expected 1/0", proto_err, outstanding_cnt);
    end
    check_drained("err");
  endtask

  task automatic test_reset_midop();
    apply_reset();
    sb_en = 1'b0;
    src_req_val = '1;
    eng_req_rdy = 1'b1;
    repeat (5) tick();
    src_req_val = '0;
    eng_req_rdy = 1'b0;
    @(negedge clk);
    tests++;
    if (outstanding_cnt !== 4'd5 || eng_req_val !== 1'b1) begin
      fails++;
      $display("FAIL midop_setup: got cnt=%0d val=%0b, expected 5/1", outstanding_cnt, eng_req_val);
    end
    tick();
    src_req_val = '1;
    eng_data_val = 1'b1;
    dst_data_rdy = '1;
    rst_n = 1'b0;
    #2;
    tests++;
    if ({eng_req_val, src_req_rdy, dst_data_val, eng_data_rdy, outstanding_cnt, proto_err} !== '0) begin
      fails++;
      $display("FAIL midop_reset: got val=%0b rdy=%b dval=%b drdy=%0b cnt=%0d err=%0b, expected all 0",
               eng_req_val, src_req_rdy, dst_data_val, eng_data_rdy, outstanding_cnt, proto_err);
    end
    tick();
    eng_data_val = 1'b0;
    rst_n = 1'b1;
    eng_req_rdy = 1'b1;
    @(negedge clk);
    tests++;
    if (src_req_rdy !== 4'b0001 || outstanding_cnt !== 4'd0) begin
      fails++;
      $display("FAIL midop_first_grant: got rdy=%b cnt=%0d, expected 0001/0", src_req_rdy, outstanding_cnt);
    end
    apply_reset();
    sb_en = 1'b1;
  endtask

  initial begin
    default_fields();
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_routing();
    test_error();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
